// File: rtl/icache.sv
// rtl/icache.sv - direct-mapped instruction cache with single-line refill
//
// Purpose: answers word fetches from a tag/data array. A miss sequences one
// line refill over the mem_en/mem_done handshake, writes the line and forwards
// the requested word. Rollback suppresses the response but never aborts a
// refill that is already in flight.
//
// Optional feature: define ICACHE_PERF_EN to build the hit/miss counters.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   rdy               global enable; all registers hold while low
//   rollback          pipeline flush
//   fetch_en/fetch_pc fetch request, held until fetch_valid
//   fetch_valid/inst  one-cycle response pulse and instruction word
//   mem_en/mem_pc     line refill request and line-aligned address
//   mem_done/mem_line refill completion pulse and line data
//   hit_cnt/miss_cnt  performance counters (0 when the feature is off)
module icache #(
  parameter int LINE_BYTES = 16,
  parameter int LINES      = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy,
  input  logic                    rollback,
  input  logic                    fetch_en,
  input  logic [31:0]             fetch_pc,
  output logic                    fetch_valid,
  output logic [31:0]             fetch_inst,
  output logic                    mem_en,
  output logic [31:0]             mem_pc,
  input  logic                    mem_done,
  input  logic [LINE_BYTES*8-1:0] mem_line,
  output logic [31:0]             hit_cnt,
  output logic [31:0]             miss_cnt
);

  localparam int OFF   = $clog2(LINE_BYTES);
  localparam int IDX   = $clog2(LINES);
  localparam int TAGW  = 32 - OFF - IDX;
  localparam int LW    = LINE_BYTES * 8;
  localparam int WORDS = LINE_BYTES / 4;

  typedef enum logic {
    IDLE,
    MISS
  } state_t;

  state_t            state_q, state_d;
  logic              drop_q, drop_d;
  logic [31:0]       req_pc_q, req_pc_d;
  logic              fetch_valid_d;
  logic [31:0]       fetch_inst_d;
  logic              mem_en_d;
  logic [31:0]       mem_pc_d;
  logic              fill;

  logic [LINES-1:0]  valid_q;
  logic [TAGW-1:0]   tag_arr  [LINES];
  logic [LW-1:0]     data_arr [LINES];

  logic [IDX-1:0]    f_idx, r_idx;
  logic [TAGW-1:0]   f_tag, r_tag;
  logic              accept, hit;

  // Little-endian word select within a line; pc[1:0] are dropped by the shift.
  function automatic logic [31:0] sel_word(input logic [LW-1:0] line,
                                           input logic [31:0] pc);
    int w;
    w = int'((pc >> 2) % WORDS);
    return line[w*32 +: 32];
  endfunction

  assign f_idx  = fetch_pc[OFF+IDX-1:OFF];
  assign f_tag  = fetch_pc[31:OFF+IDX];
  assign r_idx  = req_pc_q[OFF+IDX-1:OFF];
  assign r_tag  = req_pc_q[31:OFF+IDX];

  // fetch_valid blocks acceptance so a held request is not answered twice.
  assign accept = (state_q == IDLE) && fetch_en && !fetch_valid && !rollback && rdy;
  assign hit    = valid_q[f_idx] && (tag_arr[f_idx] == f_tag);

  always_comb begin
    state_d       = state_q;
    drop_d        = drop_q;
    req_pc_d      = req_pc_q;
    fetch_valid_d = 1'b0;
    fetch_inst_d  = fetch_inst;
    mem_en_d      = mem_en;
    mem_pc_d      = mem_pc;
    fill          = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (hit) begin
            fetch_valid_d = 1'b1;
            fetch_inst_d  = sel_word(data_arr[f_idx], fetch_pc);
          end else begin
            req_pc_d = fetch_pc;
            mem_en_d = 1'b1;
            mem_pc_d = fetch_pc & ~(32'(LINE_BYTES) - 32'd1);
            drop_d   = 1'b0;
            state_d  = MISS;
          end
        end
      end
      MISS: begin
        // The memory controller cannot abort, so rollback only marks the
        // response as unwanted; the line is still installed.
        if (rollback) drop_d = 1'b1;
        if (mem_done) begin
          fill     = 1'b1;
          mem_en_d = 1'b0;
          state_d  = IDLE;
          if (!drop_q && !rollback) begin
            fetch_valid_d = 1'b1;
            fetch_inst_d  = sel_word(mem_line, req_pc_q);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (rollback) fetch_valid_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      drop_q      <= 1'b0;
      req_pc_q    <= 32'd0;
      fetch_valid <= 1'b0;
      fetch_inst  <= 32'd0;
      mem_en      <= 1'b0;
      mem_pc      <= 32'd0;
      valid_q     <= '0;
    end else if (rdy) begin
      state_q     <= state_d;
      drop_q      <= drop_d;
      req_pc_q    <= req_pc_d;
      fetch_valid <= fetch_valid_d;
      fetch_inst  <= fetch_inst_d;
      mem_en      <= mem_en_d;
      mem_pc      <= mem_pc_d;
      if (fill) valid_q[r_idx] <= 1'b1;
    end
  end

  // Tag/data contents need no reset: valid_q alone qualifies them.
  always_ff @(posedge clk) begin
    if (rdy && fill) begin
      tag_arr[r_idx]  <= r_tag;
      data_arr[r_idx] <= mem_line;
    end
  end

`ifdef ICACHE_PERF_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;

  // A miss counts when accepted, even if rollback later drops its response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt_q  <= 32'd0;
      miss_cnt_q <= 32'd0;
    end else if (accept) begin
      if (hit) hit_cnt_q  <= hit_cnt_q + 32'd1;
      else     miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`else
  assign hit_cnt  = 32'd0;
  assign miss_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_icache.sv
// tb/tb_icache.sv - directed self-checking bench for icache
module tb_icache;

  logic         clk;
  logic         rst;
  logic         rdy;
  logic         rollback;
  logic         fetch_en;
  logic [31:0]  fetch_pc;
  logic         fetch_valid;
  logic [31:0]  fetch_inst;
  logic         mem_en;
  logic [31:0]  mem_pc;
  logic         mem_done;
  logic [127:0] mem_line;
  logic [31:0]  hit_cnt;
  logic [31:0]  miss_cnt;

  int tests;
  int fails;

  localparam logic [127:0] LINE0 = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
  localparam logic [127:0] LINE1 = 128'h1F1E1D1C_1B1A1918_17161514_13121110;
  localparam logic [127:0] LINE2 = 128'h2F2E2D2C_2B2A2928_27262524_23222120;

`ifdef ICACHE_PERF_EN
  localparam logic [31:0] EXP_HITS   = 32'd3;
  localparam logic [31:0] EXP_MISSES = 32'd3;
`else
  localparam logic [31:0] EXP_HITS   = 32'd0;
  localparam logic [31:0] EXP_MISSES = 32'd0;
`endif

  icache #(.LINE_BYTES(16), .LINES(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .rdy         (rdy),
    .rollback    (rollback),
    .fetch_en    (fetch_en),
    .fetch_pc    (fetch_pc),
    .fetch_valid (fetch_valid),
    .fetch_inst  (fetch_inst),
    .mem_en      (mem_en),
    .mem_pc      (mem_pc),
    .mem_done    (mem_done),
    .mem_line    (mem_line),
    .hit_cnt     (hit_cnt),
    .miss_cnt    (miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance past one active edge; outputs are sampled 1 ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests    = 0;
    fails    = 0;
    rst      = 1'b1;
    rdy      = 1'b1;
    rollback = 1'b0;
    fetch_en = 1'b0;
    fetch_pc = 32'd0;
    mem_done = 1'b0;
    mem_line = '0;
    #12;
    rst = 1'b0;

    // Reset state
    chk("rst_fetch_valid", 32'(fetch_valid), 32'd0);
    chk("rst_fetch_inst",  fetch_inst,       32'd0);
    chk("rst_mem_en",      32'(mem_en),      32'd0);
    chk("rst_mem_pc",      mem_pc,           32'd0);
    chk("rst_hit_cnt",     hit_cnt,          32'd0);
    chk("rst_miss_cnt",    miss_cnt,         32'd0);

    // Start a miss, then reset asynchronously mid-cycle
    fetch_en = 1'b1;
    fetch_pc = 32'h0000_1004;
    step();
    chk("miss0_mem_en", 32'(mem_en), 32'd1);
    chk("miss0_mem_pc", mem_pc,      32'h0000_1000);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_mem_en", 32'(mem_en), 32'd0);
    chk("async_rst_mem_pc", mem_pc,      32'd0);
    rst = 1'b0;

    // Cold miss of 0x1004 after reset
    step();
    chk("miss1_mem_en",      32'(mem_en),      32'd1);
    chk("miss1_mem_pc",      mem_pc,           32'h0000_1000);
    step();
    chk("miss1_wait_mem_en", 32'(mem_en),      32'd1);
    chk("miss1_wait_valid",  32'(fetch_valid), 32'd0);
    mem_line = LINE0;
    mem_done = 1'b1;
    step();
    mem_done = 1'b0;
    fetch_en = 1'b0;
    chk("miss1_valid",  32'(fetch_valid), 32'd1);
    chk("miss1_inst",   fetch_inst,       32'h0706_0504);
    chk("miss1_mem_en", 32'(mem_en),      32'd0);
    step();
    chk("miss1_pulse_end", 32'(fetch_valid), 32'd0);

    // Hit on 0x100C
    fetch_en = 1'b1;
    fetch_pc = 32'h0000_100C;
    step();
    fetch_en = 1'b0;
    chk("hit1_valid",  32'(fetch_valid), 32'd1);
    chk("hit1_inst",   fetch_inst,       32'h0F0E_0D0C);
    chk("hit1_mem_en", 32'(mem_en),      32'd0);
    step();

    // Conflict miss 0x1104 evicts line 0x1000
    fetch_en = 1'b1;
    fetch_pc = 32'h0000_1104;
    step();
    chk("conf_mem_en", 32'(mem_en), 32'd1);
    chk("conf_mem_pc", mem_pc,      32'h0000_1100);
    mem_line = LINE1;
    mem_done = 1'b1;
    step();
    mem_done = 1'b0;
    fetch_en = 1'b0;
    chk("conf_inst", fetch_inst, 32'h1716_1514);
    step();

    // 0x1004 misses again, then rollback drops its response
    fetch_en = 1'b1;
    fetch_pc = 32'h0000_1004;
    step();
    fetch_en = 1'b0;
    chk("remiss_mem_en", 32'(mem_en), 32'd1);
    chk("remiss_mem_pc", mem_pc,      32'h0000_1000);
    rollback = 1'b1;
    step();
    rollback = 1'b0;
    step();
    mem_line = LINE2;
    mem_done = 1'b1;
    step();
    mem_done = 1'b0;
    chk("drop_valid",  32'(fetch_valid), 32'd0);
    chk("drop_mem_en", 32'(mem_en),      32'd0);
    step();
    chk("drop_valid_after", 32'(fetch_valid), 32'd0);

    // Dropped refill still installed: 0x1008 hits
    fetch_en = 1'b1;
    fetch_pc = 32'h0000_1008;
    step();
    fetch_en = 1'b0;
    chk("drop_hit_valid",  32'(fetch_valid), 32'd1);
    chk("drop_hit_inst",   fetch_inst,       32'h2B2A_2928);
    chk("drop_hit_mem_en", 32'(mem_en),      32'd0);
    step();

    // rdy stall for 3 cycles around a pending hit on 0x1004
    fetch_en = 1'b1;
    fetch_pc = 32'h0000_1004;
    rdy      = 1'b0;
    step();
    step();
    step();
    chk("stall_valid", 32'(fetch_valid), 32'd0);
    rdy = 1'b1;
    step();
    fetch_en = 1'b0;
    chk("stall_hit_valid", 32'(fetch_valid), 32'd1);
    chk("stall_hit_inst",  fetch_inst,       32'h2726_2524);
    rdy = 1'b0;
    step();
    chk("stall_hold_valid", 32'(fetch_valid), 32'd1);
    chk("stall_hold_inst",  fetch_inst,       32'h2726_2524);
    rdy = 1'b1;
    step();
    chk("stall_release_valid", 32'(fetch_valid), 32'd0);

    // Counters: hits 0x100C/0x1008/0x1004, misses 0x1004/0x1104/0x1004
    chk("perf_hit_cnt",  hit_cnt,  EXP_HITS);
    chk("perf_miss_cnt", miss_cnt, EXP_MISSES);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
